// File: rtl/dds_pkg.sv
// Shared quadrant type, default widths and magnitude clamp for the quarter-wave DDS.
package dds_pkg;

   typedef enum logic [1:0] {
      Q0_POS        = 2'd0,
      Q1_POS_MIRROR = 2'd1,
      Q2_NEG        = 2'd2,
      Q3_NEG_MIRROR = 2'd3
   } quadrant_t;

   localparam int DEF_PHASE_W = 16;
   localparam int DEF_LUT_AW  = 5;
   localparam int DEF_DATA_W  = 8;

   // Limit to the largest positive value so the later negation never overflows.
   function automatic logic [31:0] clamp_mag(input logic [31:0] mag, input int unsigned data_w);
      logic [31:0] lim;
      lim = (32'd1 << (data_w - 1)) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/dds_quarter_wave_phase_acc.sv
// Phase accumulator with load-over-enable priority; DDS_WRAP_PULSE_EN adds a registered carry flag.
module dds_phase_acc
   import dds_pkg::*;
#(
   parameter int PHASE_W = DEF_PHASE_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               phase_load,
   input  logic [PHASE_W-1:0] phase_init,
   input  logic [PHASE_W-1:0] tuning_word,
   output logic [PHASE_W-1:0] phase
`ifdef DDS_WRAP_PULSE_EN
   ,
   output logic               wrap
`endif
);

`ifdef DDS_WRAP_PULSE_EN
   logic [PHASE_W:0] sum;
   assign sum = {1'b0, phase} + {1'b0, tuning_word};

   // wrap marks that the value now in the phase register came from an overflowing add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
         wrap  <= 1'b0;
      end else if (phase_load) begin
         phase <= phase_init;
         wrap  <= 1'b0;
      end else if (en) begin
         phase <= sum[PHASE_W-1:0];
         wrap  <= sum[PHASE_W];
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (phase_load) begin
         phase <= phase_init;
      end else if (en) begin
         phase <= phase + tuning_word;
      end
   end
`endif

endmodule

// File: rtl/dds_quarter_wave.sv
// Quarter-wave sine DDS front-end: phase decode, LUT addressing with mirroring, 2-stage pipe.
// Optional macro DDS_WRAP_PULSE_EN adds the wrap_pulse output.
module dds_quarter_wave
   import dds_pkg::*;
#(
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int LUT_AW  = DEF_LUT_AW,
   parameter int DATA_W  = DEF_DATA_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     phase_load,
   input  logic [PHASE_W-1:0]       phase_init,
   input  logic [PHASE_W-1:0]       tuning_word,
   output logic [LUT_AW-1:0]        lut_addr,
   input  logic [DATA_W-1:0]        lut_data,
   output logic signed [DATA_W-1:0] sample,
   output logic                     sample_valid
`ifdef DDS_WRAP_PULSE_EN
   ,
   output logic                     wrap_pulse
`endif
);

   logic [PHASE_W-1:0] phase;
   quadrant_t          quad;
   logic [LUT_AW-1:0]  idx;
   logic               mirror;
   logic               negate;
   logic               neg_s1;
   logic [1:0]         fill_reg;
   logic [DATA_W-1:0]  mag;
   logic               valid_next;
`ifdef DDS_WRAP_PULSE_EN
   logic               wrap_flag;
   logic               wrap_s1;
`endif

   dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .phase_load  (phase_load),
      .phase_init  (phase_init),
      .tuning_word (tuning_word),
      .phase       (phase)
`ifdef DDS_WRAP_PULSE_EN
      ,
      .wrap        (wrap_flag)
`endif
   );

   assign quad   = quadrant_t'(phase[PHASE_W-1 -: 2]);
   assign idx    = phase[PHASE_W-3 -: LUT_AW];
   assign mirror = (quad == Q1_POS_MIRROR) || (quad == Q3_NEG_MIRROR);
   assign negate = (quad == Q2_NEG) || (quad == Q3_NEG_MIRROR);
   assign mag    = DATA_W'(clamp_mag(32'(lut_data), DATA_W));

   // Phase bits below the LUT index are truncated away.
   generate
      if (PHASE_W > LUT_AW + 2) begin : g_trunc
         logic unused_lsbs;
         assign unused_lsbs = ^phase[PHASE_W-3-LUT_AW:0];
      end
   endgenerate

   // fill_reg counts enabled edges since reset/load; stage-1 data is meaningful once it is non-zero.
   assign valid_next = en && !phase_load && (fill_reg != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_addr     <= '0;
         neg_s1       <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         fill_reg     <= 2'd0;
      end else begin
         sample_valid <= valid_next;
         if (en) begin
            lut_addr <= mirror ? ~idx : idx;
            neg_s1   <= negate;
            sample   <= neg_s1 ? -mag : mag;
         end
         if (phase_load) begin
            fill_reg <= 2'd0;
         end else if (en && (fill_reg != 2'd2)) begin
            fill_reg <= fill_reg + 2'd1;
         end
      end
   end

`ifdef DDS_WRAP_PULSE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_s1    <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         wrap_pulse <= valid_next && wrap_s1;
         if (en) begin
            wrap_s1 <= wrap_flag;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dds_quarter_wave.sv
// Directed bench for dds_quarter_wave with a LUT model returning addr*4 (optionally 8'hFF at addr 31).
module tb_dds_quarter_wave;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              phase_load;
   logic [15:0]       phase_init;
   logic [15:0]       tuning_word;
   logic [4:0]        lut_addr;
   logic [7:0]        lut_data;
   logic signed [7:0] sample;
   logic              sample_valid;
`ifdef DDS_WRAP_PULSE_EN
   logic              wrap_pulse;
`endif
   logic              lut_ff31;
   int                n_total = 0;
   int                n_pass  = 0;

   always #5 clk = ~clk;

   assign lut_data = (lut_ff31 && (lut_addr == 5'd31)) ? 8'hFF : {1'b0, lut_addr, 2'b00};

   dds_quarter_wave dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .phase_load   (phase_load),
      .phase_init   (phase_init),
      .tuning_word  (tuning_word),
      .lut_addr     (lut_addr),
      .lut_data     (lut_data),
      .sample       (sample),
      .sample_valid (sample_valid)
`ifdef DDS_WRAP_PULSE_EN
      ,
      .wrap_pulse   (wrap_pulse)
`endif
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected address / sample for the k-th phase step of 512 (one LUT index per step).
   function automatic logic [4:0] exp_addr(input int k);
      int q;
      int idx;
      q   = (k / 32) % 4;
      idx = k % 32;
      return (q % 2 == 1) ? 5'(31 - idx) : 5'(idx);
   endfunction

   function automatic logic [7:0] exp_sample(input int k);
      logic [7:0] m;
      m = {1'b0, exp_addr(k), 2'b00};
      return (((k / 32) % 4) >= 2) ? -m : m;
   endfunction

   function automatic logic [7:0] exp_sample_4k(input int m);
      case (m % 4)
         1:       return 8'h7C;
         3:       return 8'h84;
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; phase_load = 1'b0; phase_init = 16'h0000;
      tuning_word = 16'h0000; lut_ff31 = 1'b0;
      tick(); tick();
      check("rst_addr", {11'd0, lut_addr}, 16'd0);
      check("rst_sample", {8'd0, sample}, 16'd0);
      check("rst_valid", {15'd0, sample_valid}, 16'd0);
`ifdef DDS_WRAP_PULSE_EN
      check("rst_wrap", {15'd0, wrap_pulse}, 16'd0);
`endif
      rst = 1'b0;
      tick();

      // Full period sweep with one index per step
      tuning_word = 16'd512; en = 1'b1;
      for (int n = 1; n <= 130; n++) begin
         tick();
         check("sweep_addr", {11'd0, lut_addr}, {11'd0, exp_addr(n - 1)});
         check("sweep_valid", {15'd0, sample_valid}, {15'd0, (n >= 2)});
         if (n >= 2) check("sweep_sample", {8'd0, sample}, {8'd0, exp_sample(n - 2)});
      end

      // Mid-stream load to the negative half
      phase_load = 1'b1; phase_init = 16'h8000;
      tick();
      check("load_valid0", {15'd0, sample_valid}, 16'd0);
      phase_load = 1'b0;
      tick();
      check("load_valid1", {15'd0, sample_valid}, 16'd0);
      check("load_addr", {11'd0, lut_addr}, 16'd0);
      tick();
      check("load_valid2", {15'd0, sample_valid}, 16'd1);
      check("load_sample0", {8'd0, sample}, 16'h0000);
      tick();
      check("load_sample1", {8'd0, sample}, 16'h00FC);

      // Clamp: oversized LUT value in the negative and positive halves
      lut_ff31 = 1'b1;
      phase_load = 1'b1; phase_init = 16'hBE00;
      tick();
      check("clampn_valid0", {15'd0, sample_valid}, 16'd0);
      phase_load = 1'b0;
      tick();
      check("clampn_addr", {11'd0, lut_addr}, 16'd31);
      tick();
      check("clampn_valid", {15'd0, sample_valid}, 16'd1);
      check("clampn_sample", {8'd0, sample}, 16'h0081);
      check("clampn_addr_q3", {11'd0, lut_addr}, 16'd31);
      phase_load = 1'b1; phase_init = 16'h3E00;
      tick();
      phase_load = 1'b0;
      tick();
      check("clampp_addr", {11'd0, lut_addr}, 16'd31);
      tick();
      check("clampp_sample", {8'd0, sample}, 16'h007F);
      lut_ff31 = 1'b0;

      // Enable toggling holds the pipe
      phase_load = 1'b1; phase_init = 16'h0000;
      tick();
      phase_load = 1'b0;
      tick(); tick(); tick();
      check("tog_sample_a", {8'd0, sample}, 16'd4);
      en = 1'b0;
      tick();
      check("tog_hold_valid", {15'd0, sample_valid}, 16'd0);
      check("tog_hold_sample", {8'd0, sample}, 16'd4);
      check("tog_hold_addr", {11'd0, lut_addr}, 16'd2);
      en = 1'b1;
      tick();
      check("tog_run_valid", {15'd0, sample_valid}, 16'd1);
      check("tog_run_sample", {8'd0, sample}, 16'd8);
      en = 1'b0;
      tick();
      check("tog_hold2_valid", {15'd0, sample_valid}, 16'd0);
      check("tog_hold2_sample", {8'd0, sample}, 16'd8);
      en = 1'b1;
      tick();
      check("tog_run2_sample", {8'd0, sample}, 16'd12);

      // Zero tuning word: constant valid output
      tuning_word = 16'd0; phase_load = 1'b1; phase_init = 16'h2000;
      tick();
      phase_load = 1'b0;
      tick(); tick();
      check("tw0_sample_a", {8'd0, sample}, 16'h0040);
      tick();
      check("tw0_valid", {15'd0, sample_valid}, 16'd1);
      check("tw0_sample_b", {8'd0, sample}, 16'h0040);
      check("tw0_addr", {11'd0, lut_addr}, 16'd16);

      // Asynchronous reset between edges
      #3 rst = 1'b1;
      #1;
      check("arst_addr", {11'd0, lut_addr}, 16'd0);
      check("arst_sample", {8'd0, sample}, 16'd0);
      check("arst_valid", {15'd0, sample_valid}, 16'd0);
      en = 1'b0;
      tick();
      rst = 1'b0;

      // Quarter-period steps from phase 0
      tuning_word = 16'h4000; en = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         tick();
         check("q4_addr", {11'd0, lut_addr}, (n % 2 == 0) ? 16'd31 : 16'd0);
         check("q4_valid", {15'd0, sample_valid}, {15'd0, (n >= 2)});
         if (n >= 2) check("q4_sample", {8'd0, sample}, {8'd0, exp_sample_4k(n - 2)});
`ifdef DDS_WRAP_PULSE_EN
         check("q4_wrap", {15'd0, wrap_pulse}, {15'd0, ((n - 2) > 0) && ((n - 2) % 4 == 0)});
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
